// File: rtl/register_file_pkg.sv
// Shared constants, types and helpers for the register_file block.
`timescale 1ns/1ps
package regfile_pkg;

  localparam int REG_ZERO   = 0;
  localparam int REG_RA     = 31;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  // popcount takes a fixed-width argument; callers zero-extend up to POP_MAX bits.
  localparam int POP_MAX    = 256;
  localparam int POP_W      = $clog2(POP_MAX) + 1;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_WIDTH-1:0]  reg_word_t;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) c = c + POP_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback bus of the register file: two read ports, write port, reserve port, scoreboard status.
`timescale 1ns/1ps
interface register_file_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              busy_a;
  logic              busy_b;
  logic              stall;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, stall, pending_cnt
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, stall, pending_cnt
  );
endinterface

// File: rtl/register_file_cell.sv
// register_cell: one WIDTH-bit storage register with load enable, async active-low clear.
`timescale 1ns/1ps
module register_cell
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH GPR file, r0 hardwired to zero, pending-write scoreboard.
// Optional write-through forwarding on the read ports with `define REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  register_file_if.slave    bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [CNT_W-1:0] pending_cnt;
  logic             wr_ok;
  logic             rsv_ok;

  assign wr_ok  = bus.wr_en  && (bus.wr_addr  != ADDR_W'(REG_ZERO));
  assign rsv_ok = bus.rsv_en && (bus.rsv_addr != ADDR_W'(REG_ZERO));

  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_cell
    register_cell #(.WIDTH(WIDTH)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .load (wr_ok && (bus.wr_addr == ADDR_W'(i))),
      .d    (bus.wr_data),
      .q    (regs[i])
    );
  end

  // Reserve is applied after release so a same-index reserve from a younger instruction wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[bus.wr_addr]  = 1'b0;
    if (rsv_ok) busy_nxt[bus.rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= CNT_W'(popcount(POP_MAX'(busy_nxt)));
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit_a;
  logic hit_b;
  logic rsv_same;

  // Gated by rst so forwarded data cannot leak onto the ports while reset is asserted.
  assign rsv_same = bus.rsv_en && (bus.rsv_addr == bus.wr_addr);
  assign hit_a    = rst && wr_ok && (bus.wr_addr == bus.rd_addr_a);
  assign hit_b    = rst && wr_ok && (bus.wr_addr == bus.rd_addr_b);

  assign bus.rd_data_a = hit_a ? bus.wr_data : regs[bus.rd_addr_a];
  assign bus.rd_data_b = hit_b ? bus.wr_data : regs[bus.rd_addr_b];
  assign bus.busy_a    = (hit_a && !rsv_same) ? 1'b0 : busy[bus.rd_addr_a];
  assign bus.busy_b    = (hit_b && !rsv_same) ? 1'b0 : busy[bus.rd_addr_b];
`else
  assign bus.rd_data_a = regs[bus.rd_addr_a];
  assign bus.rd_data_b = regs[bus.rd_addr_b];
  assign bus.busy_a    = busy[bus.rd_addr_a];
  assign bus.busy_b    = busy[bus.rd_addr_b];
`endif

  assign bus.stall       = bus.busy_a | bus.busy_b;
  assign bus.pending_cnt = pending_cnt;

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based reference model.
`timescale 1ns/1ps
module tb_register_file;
  import regfile_pkg::*;

  localparam int W  = 32;
  localparam int D  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  reg_word_t m_regs [D];
  logic      m_busy [D];

  register_file_if #(.WIDTH(W), .DEPTH(D)) bus ();
  register_file #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic void m_clear();
    for (int i = 0; i < D; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < D; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic reg_word_t exp_rd(input reg_addr_t a);
    if (!rst || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr != 0 && bus.wr_addr == a) return bus.wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input reg_addr_t a);
    if (!rst) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr != 0 && bus.wr_addr == a &&
        !(bus.rsv_en && bus.rsv_addr == bus.wr_addr)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
  endtask

  // Advance one edge; the model applies write then reserve, so reserve wins on a tie.
  task automatic tick();
    logic we, re;
    reg_addr_t wa, ra;
    reg_word_t wd;
    we = bus.wr_en && bus.wr_addr != 0;   wa = bus.wr_addr; wd = bus.wr_data;
    re = bus.rsv_en && bus.rsv_addr != 0; ra = bus.rsv_addr;
    @(posedge clk);
    if (rst) begin
      if (we) begin m_regs[wa] = wd; m_busy[wa] = 1'b0; end
      if (re) m_busy[ra] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd7;
    #1;
    checks++; if (bus.rd_data_a !== '0) begin errors++; $display("FAIL reset0 rd_data_a: got %h expected 0", bus.rd_data_a); end
    checks++; if (bus.pending_cnt !== 6'd0) begin errors++; $display("FAIL reset0 pending_cnt: got %0d expected 0", bus.pending_cnt); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset0 stall: got %b expected 0", bus.stall); end
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    tick(); idle(); #1;
    checks++; if (bus.rd_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_pre rd_data_a: got %h expected deadbeef", bus.rd_data_a); end
    checks++; if (bus.busy_b !== 1'b1) begin errors++; $display("FAIL reset_pre busy_b: got %b expected 1", bus.busy_b); end
    checks++; if (bus.pending_cnt !== 6'd1) begin errors++; $display("FAIL reset_pre pending_cnt: got %0d expected 1", bus.pending_cnt); end
    bus.rd_addr_a = 5'd7; #1;
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL reset_pre busy_a: got %b expected 1", bus.busy_a); end
    bus.rd_addr_a = 5'd5;
    rst = 1'b0; m_clear(); #1;
    checks++; if (bus.rd_data_a !== '0) begin errors++; $display("FAIL reset_async rd_data_a: got %h expected 0", bus.rd_data_a); end
    checks++; if (bus.busy_b !== 1'b0) begin errors++; $display("FAIL reset_async busy_b: got %b expected 0", bus.busy_b); end
    checks++; if (bus.pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_async pending_cnt: got %0d expected 0", bus.pending_cnt); end
    rst = 1'b1; #1;
  endtask

  task automatic test_zero_reg();
    bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h0000BABE;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
    #1;
    checks++; if (bus.rd_data_a !== '0) begin errors++; $display("FAIL zero_same rd_data_a: got %h expected 0", bus.rd_data_a); end
    checks++; if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL zero_same busy_a: got %b expected 0", bus.busy_a); end
    tick(); idle(); #1;
    checks++; if (bus.rd_data_a !== '0) begin errors++; $display("FAIL zero rd_data_a: got %h expected 0", bus.rd_data_a); end
    checks++; if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL zero busy_a: got %b expected 0", bus.busy_a); end
    checks++; if (bus.pending_cnt !== 6'd0) begin errors++; $display("FAIL zero pending_cnt: got %0d expected 0", bus.pending_cnt); end
  endtask

  task automatic test_write_read();
    reg_word_t pre;
`ifdef REGFILE_BYPASS_EN
    pre = 32'h1111BABE;
`else
    pre = 32'h0;
`endif
    bus.rd_addr_a = 5'd3; bus.rd_addr_b = 5'd3;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h1111BABE;
    #1;
    checks++; if (bus.rd_data_a !== pre) begin errors++; $display("FAIL wr_same rd_data_a: got %h expected %h", bus.rd_data_a, pre); end
    checks++; if (bus.rd_data_b !== pre) begin errors++; $display("FAIL wr_same rd_data_b: got %h expected %h", bus.rd_data_b, pre); end
    tick(); idle(); #1;
    checks++; if (bus.rd_data_a !== 32'h1111BABE) begin errors++; $display("FAIL wr rd_data_a: got %h expected 1111babe", bus.rd_data_a); end
    checks++; if (bus.rd_data_b !== 32'h1111BABE) begin errors++; $display("FAIL wr rd_data_b: got %h expected 1111babe", bus.rd_data_b); end
  endtask

  task automatic test_scoreboard();
    reg_word_t d = reg_word_t'($urandom);
    logic pre_busy;
`ifdef REGFILE_BYPASS_EN
    pre_busy = 1'b0;
`else
    pre_busy = 1'b1;
`endif
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd8; tick();
    bus.rsv_addr = 5'd9; tick(); idle();
    bus.rd_addr_a = 5'd8; bus.rd_addr_b = 5'd0; #1;
    checks++; if (bus.pending_cnt !== 6'd2) begin errors++; $display("FAIL sb pending_cnt: got %0d expected 2", bus.pending_cnt); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sb stall: got %b expected 1", bus.stall); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd8; bus.wr_data = d; #1;
    checks++; if (bus.busy_a !== pre_busy) begin errors++; $display("FAIL sb_same busy_a: got %b expected %b", bus.busy_a, pre_busy); end
    tick(); idle(); #1;
    checks++; if (bus.pending_cnt !== 6'd1) begin errors++; $display("FAIL sb_wr pending_cnt: got %0d expected 1", bus.pending_cnt); end
    checks++; if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL sb_wr busy_a: got %b expected 0", bus.busy_a); end
    checks++; if (bus.rd_data_a !== d) begin errors++; $display("FAIL sb_wr rd_data_a: got %h expected %h", bus.rd_data_a, d); end
  endtask

  task automatic test_simultaneous();
    reg_word_t d = reg_word_t'($urandom);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd10; tick(); idle();
    bus.rd_addr_a = 5'd10; #1;
    checks++; if (bus.pending_cnt !== 6'd2) begin errors++; $display("FAIL sim_pre pending_cnt: got %0d expected 2", bus.pending_cnt); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = d;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd10; #1;
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL sim_same busy_a: got %b expected 1", bus.busy_a); end
    tick(); idle(); #1;
    checks++; if (bus.rd_data_a !== d) begin errors++; $display("FAIL sim rd_data_a: got %h expected %h", bus.rd_data_a, d); end
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL sim busy_a: got %b expected 1", bus.busy_a); end
    checks++; if (bus.pending_cnt !== 6'd2) begin errors++; $display("FAIL sim pending_cnt: got %0d expected 2", bus.pending_cnt); end
  endtask

  task automatic test_reserve_all();
    for (int i = 1; i < D; i++) begin
      bus.rsv_en = 1'b1; bus.rsv_addr = reg_addr_t'(i); tick();
    end
    idle(); bus.rd_addr_a = reg_addr_t'(REG_RA); #1;
    checks++; if (bus.pending_cnt !== 6'd31) begin errors++; $display("FAIL all pending_cnt: got %0d expected 31", bus.pending_cnt); end
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL all busy_a: got %b expected 1", bus.busy_a); end
    bus.wr_en = 1'b1; bus.wr_addr = reg_addr_t'(REG_RA); bus.wr_data = 32'hCAFEF00D;
    tick(); idle(); #1;
    checks++; if (bus.pending_cnt !== 6'd30) begin errors++; $display("FAIL all_wr pending_cnt: got %0d expected 30", bus.pending_cnt); end
    checks++; if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL all_wr busy_a: got %b expected 0", bus.busy_a); end
  endtask

  task automatic test_random();
    logic eb_a, eb_b;
    for (int n = 0; n < 400; n++) begin
      bus.rd_addr_a = reg_addr_t'($urandom_range(0, D-1));
      bus.rd_addr_b = reg_addr_t'($urandom_range(0, D-1));
      bus.wr_en     = ($urandom_range(0, 1) == 1);
      bus.wr_addr   = ($urandom_range(0, 3) == 0) ? bus.rd_addr_a : reg_addr_t'($urandom_range(0, D-1));
      bus.wr_data   = reg_word_t'($urandom);
      bus.rsv_en    = ($urandom_range(0, 2) == 0);
      bus.rsv_addr  = ($urandom_range(0, 3) == 0) ? bus.wr_addr : reg_addr_t'($urandom_range(0, D-1));
      #1;
      eb_a = exp_busy(bus.rd_addr_a);
      eb_b = exp_busy(bus.rd_addr_b);
      checks++; if (bus.rd_data_a !== exp_rd(bus.rd_addr_a)) begin errors++; $display("FAIL rand rd_data_a[%0d]: got %h expected %h", bus.rd_addr_a, bus.rd_data_a, exp_rd(bus.rd_addr_a)); end
      checks++; if (bus.rd_data_b !== exp_rd(bus.rd_addr_b)) begin errors++; $display("FAIL rand rd_data_b[%0d]: got %h expected %h", bus.rd_addr_b, bus.rd_data_b, exp_rd(bus.rd_addr_b)); end
      checks++; if (bus.busy_a !== eb_a) begin errors++; $display("FAIL rand busy_a[%0d]: got %b expected %b", bus.rd_addr_a, bus.busy_a, eb_a); end
      checks++; if (bus.busy_b !== eb_b) begin errors++; $display("FAIL rand busy_b[%0d]: got %b expected %b", bus.rd_addr_b, bus.busy_b, eb_b); end
      checks++; if (bus.stall !== (eb_a | eb_b)) begin errors++; $display("FAIL rand stall: got %b expected %b", bus.stall, eb_a | eb_b); end
      checks++; if (int'(bus.pending_cnt) !== m_pending()) begin errors++; $display("FAIL rand pending_cnt: got %0d expected %0d", bus.pending_cnt, m_pending()); end
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b0; m_clear(); #1;
        checks++; if (bus.pending_cnt !== 6'd0) begin errors++; $display("FAIL rand_rst pending_cnt: got %0d expected 0", bus.pending_cnt); end
        checks++; if (bus.rd_data_a !== '0) begin errors++; $display("FAIL rand_rst rd_data_a: got %h expected 0", bus.rd_data_a); end
        rst = 1'b1;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    m_clear();
    idle();
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    test_reset();
    test_zero_reg();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_reserve_all();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
